// File: rtl/laser_pkg.sv
// Shared laser-link definitions: receiver states, frame geometry and line levels.
package laser_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_LOW
  } rx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W       = 4;
  localparam logic        LINE_IDLE       = 1'b0;
  localparam logic        START_LEVEL     = 1'b1;

endpackage

// File: rtl/laser_frame_receiver_if.sv
// Byte-output bus of the laser receiver: master is the receiver, slave the consumer.
interface laser_frame_receiver_if;
  import laser_pkg::*;

  logic                       data_valid;
  logic [FRAME_DATA_BITS-1:0] data_in;
  logic                       framing_err;
  logic                       busy;

  modport master (output data_valid, output data_in, output framing_err, output busy);
  modport slave  (input  data_valid, input  data_in, input  framing_err, input  busy);

endinterface

// File: rtl/laser_sync.sv
// Metastability flop chain for the asynchronous photodiode input.
module laser_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/laser_frame_receiver.sv
// Laser link receiver: oversamples the line, samples mid-cell, emits bytes or framing errors.
// Optional even-parity cell after the data bits when LASER_PARITY_EN is defined.
module laser_frame_receiver
  import laser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          laser_in,
  laser_frame_receiver_if.master        rx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]     CNT_MID   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(FRAME_DATA_BITS);

  rx_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]       bit_q, bit_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic [FRAME_DATA_BITS-1:0] data_q, data_d;
  logic                       dv_q, dv_d;
  logic                       err_q, err_d;
  logic                       busy_q;
  logic                       par_ok;
  logic                       mid;
  logic                       s;

  laser_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (laser_in),
    .q     (s)
  );

  // Cell counter runs from the start-edge cycle, so every bit is sampled at the same count.
  assign mid = (cnt_q == CNT_MID);

`ifdef LASER_PARITY_EN
  logic par_q, par_d;
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
`ifdef LASER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (en && (s == START_LEVEL)) begin
          state_d = RX_START;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (mid) state_d = (s == START_LEVEL) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: begin
        if (mid) begin
          shift_d = {s, shift_q[FRAME_DATA_BITS-1:1]};
          if (bit_q != BITS_FULL) bit_d = bit_q + BIT_CNT_W'(1);
          if (bit_q == LAST_BIT) begin
`ifdef LASER_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef LASER_PARITY_EN
      RX_PARITY: begin
        if (mid) begin
          par_d   = s;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (mid) begin
          if ((s == LINE_IDLE) && par_ok) begin
            dv_d    = 1'b1;
            data_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = (s == LINE_IDLE) ? RX_IDLE : RX_WAIT_LOW;
          end
        end
      end
      RX_WAIT_LOW: begin
        if (s == LINE_IDLE) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    // Disabling abandons the frame silently and keeps the last good byte.
    if (!en) begin
      state_d = RX_IDLE;
      dv_d    = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
    end

    if (state_d == RX_IDLE)    cnt_d = '0;
    else if (cnt_q == CNT_LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LASER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      busy_q  <= (state_d != RX_IDLE);
`ifdef LASER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx.data_valid  = dv_q;
  assign rx.data_in     = data_q;
  assign rx.framing_err = err_q;
  assign rx.busy        = busy_q;

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Randomized bench for laser_frame_receiver against a cycle-schedule model built from frame timing.
// Honours LASER_PARITY_EN the same way as the design.
module tb_laser_frame_receiver;

  localparam int N    = 8;
  localparam int H    = N / 2;
  localparam int SYNC = 2;
`ifdef LASER_PARITY_EN
  localparam int PCELLS = 1;
`else
  localparam int PCELLS = 0;
`endif
  // Raw-line start drive to visible output pulse: sync delay + mid-cell + data(+parity) cells + register.
  localparam int LAT  = SYNC + H + (9 + PCELLS) * N + 1;
  localparam int MAXC = 8192;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic laser_in = 1'b0;

  always #5 clock = ~clock;

  laser_frame_receiver_if rx_if ();

  laser_frame_receiver #(.CLKS_PER_BIT(N), .SYNC_STAGES(SYNC)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .laser_in (laser_in),
    .rx       (rx_if)
  );

  bit         exp_dv     [MAXC];
  bit         exp_err    [MAXC];
  logic [7:0] exp_byte   [MAXC];
  bit         exp_clr    [MAXC];
  bit         busy_known [MAXC];
  bit         exp_busy   [MAXC];

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic set_busy(input int lo, input int hi, input bit v);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < MAXC) begin
        busy_known[i] = 1'b1;
        exp_busy[i]   = v;
      end
    end
  endtask

  // One clock: check outputs on the falling edge, then drive the next inputs.
  task automatic tick(input logic line, input logic en_v, input logic rst_v);
    @(negedge clock);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    if (exp_clr[cyc]) model_data = 8'h00;
    if (exp_dv[cyc])  model_data = exp_byte[cyc];
    check("data_valid",  32'(rx_if.data_valid),  32'(exp_dv[cyc]));
    check("framing_err", 32'(rx_if.framing_err), 32'(exp_err[cyc]));
    check("data_in",     32'(rx_if.data_in),     32'(model_data));
    if (busy_known[cyc]) check("busy", 32'(rx_if.busy), 32'(exp_busy[cyc]));
    laser_in = line;
    en       = en_v;
    reset    = rst_v;
  endtask

  task automatic gap(input int n);
    repeat (n) tick(1'b0, 1'b1, 1'b0);
  endtask

  // abort: 0 none, 1 drop en mid-frame, 2 hold reset mid-frame
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int hold, input int abort);
    logic q[$];
    int   k, d, m;
    bit   par_bad_eff;
    for (int i = 0; i < N; i++) q.push_back(1'b1);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < N; i++) q.push_back(b[j]);
`ifdef LASER_PARITY_EN
    for (int i = 0; i < N; i++) q.push_back((^b) ^ bad_par);
    par_bad_eff = bad_par;
`else
    par_bad_eff = 1'b0;
`endif
    if (bad_stop) for (int i = 0; i < hold; i++) q.push_back(1'b1);
    else          for (int i = 0; i < N; i++)    q.push_back(1'b0);

    k = cyc + 1;
    d = k + SYNC + 1 + H + 5 * N;
    m = k + q.size();
    set_busy(k, k + 2, 1'b0);
    if (abort == 0) begin
      if (bad_stop) begin
        exp_err[k + LAT] = 1'b1;
        set_busy(k + 3, m + 2, 1'b1);
        set_busy(m + 3, m + 3, 1'b0);
      end else begin
        if (par_bad_eff) exp_err[k + LAT] = 1'b1;
        else begin
          exp_dv[k + LAT]   = 1'b1;
          exp_byte[k + LAT] = b;
        end
        set_busy(k + 3, k + LAT - 1, 1'b1);
        set_busy(k + LAT, k + LAT, 1'b0);
      end
    end else begin
      set_busy(k + 3, d, 1'b1);
      set_busy(d + 1, d + 1, 1'b0);
      if (abort == 2) exp_clr[d + 1] = 1'b1;
    end

    for (int i = 0; i < q.size(); i++)
      tick(q[i], !(abort == 1 && (k + i) >= d), (abort == 2 && (k + i) >= d));
    if (abort != 0) repeat (3) tick(1'b0, abort != 1, abort == 2);
    if (bad_stop) gap(4);
  endtask

  task automatic glitch(input int len);
    int k;
    k = cyc + 1;
    set_busy(k, k + 2, 1'b0);
    set_busy(k + 3, k + 2 + H, 1'b1);
    set_busy(k + 3 + H, k + 3 + H, 1'b0);
    repeat (len) tick(1'b1, 1'b1, 1'b0);
    gap(N + 2);
  endtask

  initial begin
    int r;
    set_busy(1, 5, 1'b0);
    exp_clr[1] = 1'b1;
    repeat (5) tick(1'b0, 1'b1, 1'b1);
    gap(3);

    send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
    gap(5);
    send_frame(8'h00, 1'b0, 1'b0, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 0, 0);
    gap(5);
    glitch(3);
    send_frame(8'h3C, 1'b0, 1'b1, 20, 0);
    gap(3);
    send_frame(8'h77, 1'b0, 1'b0, 0, 1);
    gap(2);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    gap(2);
    send_frame(8'h66, 1'b0, 1'b0, 0, 2);
    gap(2);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    gap(2);
`ifdef LASER_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 0, 0);
    gap(2);
    send_frame(8'h01, 1'b0, 1'b0, 0, 0);
    gap(2);
`endif

    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       send_frame(8'($urandom), 1'b0, 1'b1, $urandom_range(12, 30), 0);
        7:       glitch($urandom_range(1, 3));
        8:       send_frame(8'($urandom), 1'b1, 1'b0, 0, 0);
        9:       send_frame(8'($urandom), 1'b0, 1'b0, 0, 0);
        default: begin
          send_frame(8'($urandom), 1'b0, 1'b0, 0, 0);
          gap($urandom_range(0, 10));
        end
      endcase
    end

    gap(LAT + 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
